// File: rtl/dephase_pkg.sv
// rtl/dephase_pkg.sv - shared states, class/phase codes and window classifier for the dephaser
package dephase_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REF,
        ACC,
        DONE,
        ABORT
    } state_t;

    localparam logic [1:0] CLS_INV   = 2'b00;
    localparam logic [1:0] PHASE_POS = 2'b10;
    localparam logic [1:0] PHASE_NEG = 2'b01;

    // Signed window test: magnitude inside [lo, hi] on either side of zero.
    function automatic logic [1:0] classify(input longint s, input longint lo, input longint hi);
        if (s >= lo && s <= hi)
            return PHASE_POS;
        else if (s >= -hi && s <= -lo)
            return PHASE_NEG;
        else
            return CLS_INV;
    endfunction

endpackage

// File: rtl/dephase_vote.sv
// rtl/dephase_vote.sv - majority vote over VOTE_NUM classified GRIs
module dephase_vote
    import dephase_pkg::*;
#(
    parameter int VOTE_NUM = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sum_valid,
    input  logic [1:0] sum_class,
    output logic [1:0] phase_out,
    output logic       phase_valid,
    output logic       phase_lock,
    output logic [7:0] vote_conf
);

    logic [7:0] pos_cnt, neg_cnt, inv_cnt, gri_cnt;
    logic [7:0] pos_n, neg_n, inv_n, gri_n;
    logic [8:0] valid_tot;
    logic       last;

    always_comb begin
        pos_n     = pos_cnt + {7'd0, sum_class == PHASE_POS};
        neg_n     = neg_cnt + {7'd0, sum_class == PHASE_NEG};
        inv_n     = inv_cnt + {7'd0, sum_class == CLS_INV};
        gri_n     = gri_cnt + 8'd1;
        valid_tot = {1'b0, pos_n} + {1'b0, neg_n};
        last      = sum_valid && (gri_n == 8'(VOTE_NUM));
    end

    // The closing sample is folded in and decided on the same edge, so the
    // counters are already clear for any sample in the following cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_cnt     <= '0;
            neg_cnt     <= '0;
            inv_cnt     <= '0;
            gri_cnt     <= '0;
            phase_out   <= PHASE_POS;
            phase_valid <= 1'b0;
            phase_lock  <= 1'b0;
            vote_conf   <= '0;
        end else begin
            phase_valid <= 1'b0;
            if (last) begin
                pos_cnt     <= '0;
                neg_cnt     <= '0;
                inv_cnt     <= '0;
                gri_cnt     <= '0;
                phase_valid <= 1'b1;
                vote_conf   <= (neg_n >= pos_n) ? neg_n : pos_n;
                phase_lock  <= (valid_tot != 9'd0);
                if (valid_tot != 9'd0)
                    phase_out <= (neg_n >= pos_n) ? PHASE_NEG : PHASE_POS;
            end else if (sum_valid) begin
                pos_cnt <= pos_n;
                neg_cnt <= neg_n;
                inv_cnt <= inv_n;
                gri_cnt <= gri_n;
            end
        end
    end

endmodule

// File: rtl/dephase_vote_core.sv
// rtl/dephase_vote_core.sv - Loran-C phase-code decoder: GRI edge detect, deviation accumulator, watchdog, vote
module dephase_vote_core
    import dephase_pkg::*;
#(
    parameter int IDX_W         = 16,
    parameter int SUM_W         = 20,
    parameter int PULSE_NUM     = 8,
    parameter int PULSE_SPACING = 1000,
    parameter int MASTER_OFFSET = 9000,
    parameter int WIN_LO        = 12,
    parameter int WIN_HI        = 23,
    parameter int VOTE_NUM      = 10,
    parameter int TIMEOUT_CYC   = 65535
) (
    input  logic                    sys_clk,
    input  logic                    sys_rstn,
    input  logic                    gri_data_valid,
    input  logic                    gri_master,
    input  logic                    cor_peak_valid,
    input  logic [IDX_W-1:0]        cor_peak_index,
    output logic signed [SUM_W-1:0] sum_out,
    output logic                    sum_valid,
    output logic [1:0]              sum_class,
    output logic [1:0]              phase_out,
    output logic                    phase_valid,
    output logic                    phase_lock,
    output logic [7:0]              vote_conf
);

    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    if (SUM_W < IDX_W + 4) begin : g_sum_w_check
        $error("dephase_vote_core: SUM_W must be at least IDX_W+4");
    end

    state_t                  state, next_state;
    logic                    gdv_d1, gdv_d2, gri_start, restart, is_master, timeout, in_grab;
    logic [4:0]              target, k, k_next;
    logic [IDX_W-1:0]        ref_idx;
    logic signed [SUM_W-1:0] exp_off, sum, dev, sum_next;
    logic [WD_W-1:0]         wd, wd_next;

    always_comb begin
        gri_start = gdv_d1 & ~gdv_d2;
        in_grab   = (state == REF) || (state == ACC);
        dev       = $signed({{(SUM_W-IDX_W){1'b0}}, cor_peak_index})
                  - $signed({{(SUM_W-IDX_W){1'b0}}, ref_idx}) - exp_off;
        sum_next  = sum + dev;
        k_next    = k + 5'd1;
        wd_next   = wd + 1'b1;
        timeout   = !cor_peak_valid && (wd_next == WD_W'(TIMEOUT_CYC));
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (gri_start) next_state = REF;
            REF: begin
                if (gri_start)           next_state = ABORT;
                else if (cor_peak_valid) next_state = ACC;
                else if (timeout)        next_state = ABORT;
            end
            ACC: begin
                if (gri_start)           next_state = ABORT;
                else if (cor_peak_valid) next_state = (k_next == target) ? DONE : ACC;
                else if (timeout)        next_state = ABORT;
            end
            DONE:  next_state = gri_start ? REF : IDLE;
            ABORT: next_state = (gri_start || restart) ? REF : IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) state <= IDLE;
        else           state <= next_state;
    end

    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            gdv_d1    <= 1'b0;
            gdv_d2    <= 1'b0;
            restart   <= 1'b0;
            is_master <= 1'b0;
            target    <= 5'(PULSE_NUM);
            k         <= '0;
            ref_idx   <= '0;
            exp_off   <= '0;
            sum       <= '0;
            wd        <= '0;
            sum_out   <= '0;
            sum_valid <= 1'b0;
            sum_class <= CLS_INV;
        end else begin
            gdv_d1    <= gri_data_valid;
            gdv_d2    <= gdv_d1;
            restart   <= gri_start && in_grab;
            sum_valid <= 1'b0;
            wd        <= (cor_peak_valid || !in_grab) ? '0 : wd_next;
            if (gri_start) begin
                is_master <= gri_master;
                target    <= gri_master ? 5'(PULSE_NUM + 1) : 5'(PULSE_NUM);
            end
            // An abort while still in REF reports a zero partial sum.
            if (next_state == REF && state != REF)
                sum <= '0;
            if (state == REF && !gri_start && cor_peak_valid) begin
                ref_idx <= cor_peak_index;
                k       <= 5'd1;
                exp_off <= SUM_W'(PULSE_SPACING);
                sum     <= '0;
            end
            if (state == ACC && !gri_start && cor_peak_valid) begin
                sum     <= sum_next;
                k       <= k_next;
                exp_off <= (is_master && k_next == 5'(PULSE_NUM)) ? SUM_W'(MASTER_OFFSET)
                                                                  : exp_off + SUM_W'(PULSE_SPACING);
            end
            if (next_state == DONE) begin
                sum_valid <= 1'b1;
                sum_out   <= sum_next;
                sum_class <= classify(longint'(sum_next), longint'(WIN_LO), longint'(WIN_HI));
            end else if (next_state == ABORT) begin
                sum_valid <= 1'b1;
                sum_out   <= sum;
                sum_class <= CLS_INV;
            end
        end
    end

    dephase_vote #(.VOTE_NUM(VOTE_NUM)) u_vote (
        .clk         (sys_clk),
        .rst_n       (sys_rstn),
        .sum_valid   (sum_valid),
        .sum_class   (sum_class),
        .phase_out   (phase_out),
        .phase_valid (phase_valid),
        .phase_lock  (phase_lock),
        .vote_conf   (vote_conf)
    );

endmodule

// File: doc/dephase_vote_core.md
Name: dephase_vote_core

Overview:
- Parametrised Loran-C phase-code decoder. Successor to the fixed 8/9-pulse, 10-GRI dephaser.
- Sits after the correlator. Each GRI it collects correlation-peak indices and sums their deviation from the nominal pulse grid. It classifies each sum as +phase, -phase or invalid.
- Majority-votes over VOTE_NUM GRIs and emits a 2-bit phase code, a confidence count and a lock flag.
- New versus the previous generation: parametrised pulse count, spacing, window and vote depth; peak-wait watchdog; restart on early GRI start; invalid-GRI accounting; lock/confidence outputs.

Parameters:
- IDX_W, 16: peak index width (unsigned).
- SUM_W, 20: signed deviation-sum width; must be ≥ IDX_W+4.
- PULSE_NUM, 8: pulses per group for a secondary station (2..15).
- PULSE_SPACING, 1000: nominal index distance between consecutive pulses.
- MASTER_OFFSET, 9000: nominal offset of the extra master pulse from pulse 0.
- WIN_LO, 12: minimum |sum| accepted as a valid phase decision.
- WIN_HI, 23: maximum |sum| accepted.
- VOTE_NUM, 10: GRIs per vote window (1..255).
- TIMEOUT_CYC, 65535: maximum cycles between consecutive peaks before the GRI is aborted.

Ports:
- sys_clk, in, 1: clock.
- sys_rstn, in, 1: reset, asynchronous, active-low.
- gri_data_valid, in, 1: GRI data window. A rising edge starts a GRI.
- gri_master, in, 1: 1 = master station (PULSE_NUM+1 pulses), 0 = secondary (PULSE_NUM pulses). Sampled at GRI start.
- cor_peak_valid, in, 1: one-cycle strobe for a correlation peak.
- cor_peak_index, in, IDX_W: peak index, valid while cor_peak_valid is high.
- sum_out, out, SUM_W: signed deviation sum of the last completed GRI.
- sum_valid, out, 1: one-cycle strobe for sum_out/sum_class.
- sum_class, out, 2: 00 invalid, 10 positive, 01 negative.
- phase_out, out, 2: decided phase code; 10 = positive, 01 = negative.
- phase_valid, out, 1: one-cycle strobe at the end of each vote window.
- phase_lock, out, 1: 1 when the last window held at least one valid decision.
- vote_conf, out, 8: winning count of the last window.

Behaviour:
- Reset values: sum_out 0, sum_valid 0, sum_class 00, phase_out 10, phase_valid 0, phase_lock 0, vote_conf 0. The FSM returns to IDLE and all counters clear.
- Reset mid-GRI or mid-window discards everything.
- GRI start: gri_data_valid is registered twice. gri_start = d1 & ~d2, i.e. two cycles after the input rises.
- gri_master is latched into the pulse target: PULSE_NUM, or PULSE_NUM+1 for master.
- FSM states:
  - IDLE: gri_start → REF. A cor_peak_valid in this cycle is ignored.
  - REF: the first peak captures ref_idx. Set k=1, exp_off=PULSE_SPACING, sum=0, then go to ACC.
  - ACC: on each peak, sum += (index − ref_idx − exp_off), sign-extended to SUM_W; k++.
    - Next exp_off = exp_off + PULSE_SPACING.
    - For master, when k reaches PULSE_NUM, the next exp_off is MASTER_OFFSET instead.
    - exp_off is an adder, not a multiplier.
    - After the peak that makes k equal the target → DONE.
  - DONE: one cycle. sum_valid=1 with class. → IDLE.
  - ABORT: one cycle. sum_valid=1, sum_class=00, sum_out holds the partial sum. → IDLE.
- Watchdog:
  - In REF/ACC, a counter clears on every peak.
  - Reaching TIMEOUT_CYC → ABORT.
- gri_start seen in REF/ACC: abort the current GRI (counted invalid), then go to REF on the next cycle. A peak in that same cycle is dropped.
- Classification (signed compare):
  - +WIN_LO ≤ sum ≤ +WIN_HI → 10.
  - −WIN_HI ≤ sum ≤ −WIN_LO → 01.
  - Otherwise → 00.
- Vote stage, on each sum_valid:
  - Increment pos_cnt, neg_cnt or inv_cnt, and gri_cnt.
  - When gri_cnt reaches VOTE_NUM, on the next cycle:
    - phase_valid=1 and vote_conf=max(pos,neg).
    - phase_lock = (pos+neg ≠ 0).
    - phase_out = 01 if neg ≥ pos (tie → 01), else 10.
    - If pos+neg = 0, phase_out holds its previous value.
    - All counters clear in the same cycle.
- A sum_valid arriving in the decision cycle is counted into the new window.
- Latency: sum_valid is 1 cycle after the final peak. phase_valid is 1 cycle after the VOTE_NUM-th sum_valid.
- Arithmetic: all subtractions use SUM_W signed. No saturation. A SUM_W violation is a parameter error, caught by an elaboration assertion.

Decomposition:
- Package dephase_pkg holds:
  - FSM state enum: IDLE, REF, ACC, DONE, ABORT.
  - Class/phase codes: CLS_INV=00, PHASE_POS=10, PHASE_NEG=01.
  - Helper function for signed window classification.
- One sub-module: dephase_vote. It holds the counters and decision logic and is fed by sum_valid/sum_class. The top holds the edge detect, FSM, accumulator and watchdog.

Test Plan:
- Secondary, PULSE_NUM=8. Peaks at 100, 1102, 2102, 3102, 4102, 5102, 6102, 7102 → sum=14, class 10. After 10 such GRIs: phase_out=10, vote_conf=10, phase_lock=1.
- Master. Peaks 200, 1198, …, 7198, 9198 → sum=−16, class 01. Ten GRIs → phase_out=01.
- Five positive (sum=14) and five negative (sum=−14) GRIs → tie, phase_out=01, vote_conf=5.
- Only 3 peaks, then silence for TIMEOUT_CYC=100 cycles → ABORT, sum_valid with class 00. The next GRI decodes normally.
- Ten GRIs with sum=40 → phase_lock=0, vote_conf=0, phase_out keeps 10 from reset.
- gri_start mid-ACC, and separately sys_rstn asserted mid-window: the first is counted as one invalid GRI and restarts at REF. The second clears all outputs asynchronously, and the first vote after release needs a full VOTE_NUM GRIs.
